// File: rtl/cd_pila.sv
// Single-cycle datapath with a return-address stack for call/return.
// Holds PC, 16-entry register file, zero flag and stack occupancy/error state.
module cd_pila #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 10,
  parameter int STACK_D = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [31:0]               instr,
  output logic [PC_W-1:0]           pc,
  input  logic                      s_inc,
  input  logic                      s_call,
  input  logic                      s_ret,
  input  logic                      s_inm,
  input  logic                      s_datos,
  input  logic                      we3,
  input  logic                      wez,
  input  logic [2:0]                op_alu,
  input  logic [DATA_W-1:0]         datos,
  output logic [5:0]                opcode,
  output logic                      z,
  output logic [DATA_W-1:0]         direcciones,
  output logic                      stk_ovf,
  output logic                      stk_unf,
  output logic [$clog2(STACK_D):0]  stk_cnt
);

  localparam int SP_W  = $clog2(STACK_D);
  localparam int CNT_W = SP_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_D);

  logic [DATA_W-1:0] rf_q  [16];
  logic [PC_W-1:0]   stk_q [STACK_D];
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              z_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;

  logic [3:0]        ra1, ra2, wa3;
  logic [DATA_W-1:0] rd1, rd2, imm_ext, alu_a, alu_y, wd3;
  logic              zalu;
  logic [PC_W-1:0]   pc_inc, target;
  logic              full, empty;

  assign ra1    = instr[11:8];
  assign ra2    = instr[7:4];
  assign wa3    = instr[3:0];
  assign target = instr[PC_W-1:0];
  assign opcode = instr[31:26];

  // R0 is hardwired to zero on the read side; it is never written.
  assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];

  always_comb begin
    imm_ext       = {DATA_W{instr[27]}};
    imm_ext[15:0] = instr[27:12];
  end

  assign alu_a = s_inm ? rd1 : imm_ext;

  always_comb begin
    alu_y = alu_a;
    case (op_alu)
      3'b000: alu_y = alu_a;
      3'b001: alu_y = ~alu_a;
      3'b010: alu_y = alu_a + rd2;
      3'b011: alu_y = alu_a - rd2;
      3'b100: alu_y = alu_a & rd2;
      3'b101: alu_y = alu_a | rd2;
      3'b110: alu_y = '0 - alu_a;
      3'b111: alu_y = '0 - rd2;
    endcase
  end

  assign zalu = (alu_y == '0);
  assign wd3  = s_datos ? datos : alu_y;

  assign pc_inc = pc_q + PC_W'(1);
  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);

  // Call and return together is illegal: flag both and fall through sequentially.
  always_comb begin
    pc_d  = pc_inc;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (s_call && s_ret) begin
      ovf_d = 1'b1;
      unf_d = 1'b1;
    end else if (s_call) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        pc_d  = target;
      end
    end else if (s_ret) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        pc_d  = stk_q[SP_W'(cnt_q - CNT_W'(1))];
      end
    end else if (!s_inc) begin
      pc_d = target;
    end
  end

  // Stack entries carry no reset; only the occupancy count defines validity.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      z_q   <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (en) begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wez) z_q <= zalu;
      if (we3 && (wa3 != 4'd0)) rf_q[wa3] <= wd3;
      if (push) stk_q[SP_W'(cnt_q)] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign z           = z_q;
  assign direcciones = rd1;
  assign stk_ovf     = ovf_q;
  assign stk_unf     = unf_q;
  assign stk_cnt     = cnt_q;

endmodule

// File: tb/tb_cd_pila.sv
// Bench for cd_pila: directed vector table, multi-cycle stack/enable sequences,
// then random stimulus against a queue-based reference model.
module tb_cd_pila;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [31:0] instr;
  logic [9:0]  pc;
  logic        s_inc, s_call, s_ret, s_inm, s_datos, we3, wez;
  logic [2:0]  op_alu;
  logic [15:0] datos, direcciones;
  logic [5:0]  opcode;
  logic        z, stk_ovf, stk_unf;
  logic [3:0]  stk_cnt;

  cd_pila #(.DATA_W(16), .PC_W(10), .STACK_D(8)) dut (
    .clk(clk), .reset(reset), .en(en), .instr(instr), .pc(pc),
    .s_inc(s_inc), .s_call(s_call), .s_ret(s_ret), .s_inm(s_inm),
    .s_datos(s_datos), .we3(we3), .wez(wez), .op_alu(op_alu),
    .datos(datos), .opcode(opcode), .z(z), .direcciones(direcciones),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .stk_cnt(stk_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register array, integer PC, queue as the return stack.
  logic [15:0] m_rf [16];
  int          m_pc = 0;
  bit          m_z = 0, m_ovf = 0, m_unf = 0;
  int          m_stk [$];

  function automatic logic [15:0] m_rd(input int a);
    return (a == 0) ? 16'h0000 : m_rf[a];
  endfunction

  task automatic model_step();
    logic [15:0] a, b, y;
    int nxt, tgt, wa;
    a   = s_inm ? m_rd(int'(instr[11:8])) : instr[27:12];
    b   = m_rd(int'(instr[7:4]));
    wa  = int'(instr[3:0]);
    case (op_alu)
      3'd0: y = a;
      3'd1: y = ~a;
      3'd2: y = a + b;
      3'd3: y = a - b;
      3'd4: y = a & b;
      3'd5: y = a | b;
      3'd6: y = 16'h0000 - a;
      default: y = 16'h0000 - b;
    endcase
    nxt = (m_pc + 1) % 1024;
    tgt = int'(instr[9:0]);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
      m_pc = 0; m_z = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
    end else if (en) begin
      if (we3 && wa != 0) m_rf[wa] = s_datos ? datos : y;
      if (wez) m_z = (y == 16'h0000);
      if (s_call && s_ret) begin
        m_ovf = 1; m_unf = 1; m_pc = nxt;
      end else if (s_call) begin
        if (m_stk.size() == 8) begin m_ovf = 1; m_pc = nxt; end
        else begin m_stk.push_back(nxt); m_pc = tgt; end
      end else if (s_ret) begin
        if (m_stk.size() == 0) begin m_unf = 1; m_pc = nxt; end
        else m_pc = m_stk.pop_back();
      end else begin
        m_pc = s_inc ? nxt : tgt;
      end
    end
  endtask

  task automatic idle();
    reset = 0; en = 1; instr = 32'h0; s_inc = 1; s_call = 0; s_ret = 0;
    s_inm = 0; s_datos = 0; we3 = 0; wez = 0; op_alu = 3'd0; datos = 16'h0;
  endtask

  // One clock: check combinational read, advance model, check registered state.
  task automatic step();
    #1;
    if (!reset) begin
      chk("dir", direcciones, m_rd(int'(instr[11:8])));
      chk("opcode", opcode, instr[31:26]);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("z", z, m_z);
    chk("stk_cnt", stk_cnt, m_stk.size());
    chk("stk_ovf", stk_ovf, m_ovf);
    chk("stk_unf", stk_unf, m_unf);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
    chk("rst_pc", pc, 0);
    chk("rst_z", z, 0);
    chk("rst_cnt", stk_cnt, 0);
    chk("rst_flags", {stk_ovf, stk_unf}, 0);
  endtask

  function automatic logic [31:0] mk(input logic [15:0] imm, input logic [3:0] a1,
                                     input logic [3:0] a2, input logic [3:0] a3);
    return {4'h0, imm, a1, a2, a3};
  endfunction

  typedef struct {
    bit          rst;
    logic [31:0] ins;
    bit          inc, call, ret, inm, sdat, we, wz;
    logic [2:0]  op;
    logic [15:0] dat;
    logic [15:0] e_dir;
    logic [9:0]  e_pc;
    bit          e_z;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic int before_call(input int k);
    return (k == 1) ? 0 : 32'h100 + 32'h10 * (k - 2);
  endfunction

  initial begin
    //            rst ins                   inc call ret inm sdat we wz op  dat       e_dir     e_pc    e_z e_cnt
    tbl[0]  = '{1, 32'h0,                  1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h000, 0, 0};
    tbl[1]  = '{0, mk(16'h0002, 0, 0, 3),  1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0,    16'h0,    10'h001, 0, 0};
    tbl[2]  = '{0, mk(16'h0000, 3, 3, 4),  1, 0, 0, 1, 0, 1, 0, 3'd2, 16'h0,    16'h2,    10'h002, 0, 0};
    tbl[3]  = '{0, mk(16'h0000, 3, 3, 0),  1, 0, 0, 1, 0, 0, 1, 3'd3, 16'h0,    16'h2,    10'h003, 1, 0};
    tbl[4]  = '{0, mk(16'h0000, 0, 2, 0),  0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h020, 1, 0};
    tbl[5]  = '{0, mk(16'h0005, 0, 0, 0),  1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0,    16'h0,    10'h021, 1, 0};
    tbl[6]  = '{0, mk(16'h0000, 0, 0, 0),  1, 0, 0, 1, 0, 0, 1, 3'd0, 16'h0,    16'h0,    10'h022, 1, 0};
    tbl[7]  = '{0, mk(16'h0000, 4, 0, 0),  1, 0, 0, 1, 0, 0, 1, 3'd0, 16'h0,    16'h4,    10'h023, 0, 0};
    tbl[8]  = '{0, mk(16'h0000, 0, 0, 5),  0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h005, 0, 0};
    tbl[9]  = '{0, mk(16'h0000, 0, 4, 0),  1, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h040, 0, 1};
    tbl[10] = '{0, mk(16'h0000, 0, 8, 0),  1, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h080, 0, 2};
    tbl[11] = '{0, 32'h0,                  1, 0, 1, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h041, 0, 1};
    tbl[12] = '{0, 32'h0,                  1, 0, 1, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,    10'h006, 0, 0};
    tbl[13] = '{0, mk(16'h0000, 4, 0, 5),  1, 0, 0, 1, 0, 1, 1, 3'd1, 16'h0,    16'h4,    10'h007, 0, 0};
    tbl[14] = '{0, mk(16'h0000, 4, 5, 6),  1, 0, 0, 1, 0, 1, 1, 3'd7, 16'h0,    16'h4,    10'h008, 0, 0};
    tbl[15] = '{0, mk(16'h0000, 5, 4, 7),  1, 0, 0, 1, 1, 1, 1, 3'd4, 16'h8000, 16'hFFFB, 10'h009, 1, 0};
    tbl[16] = '{0, mk(16'h0000, 7, 0, 0),  1, 0, 0, 1, 0, 0, 1, 3'd6, 16'h0,    16'h8000, 10'h00A, 0, 0};
    tbl[17] = '{0, mk(16'h8001, 0, 6, 8),  1, 0, 0, 0, 0, 1, 0, 3'd2, 16'h0,    16'h0,    10'h00B, 0, 0};
    tbl[18] = '{0, mk(16'h0000, 8, 0, 0),  1, 0, 0, 1, 0, 0, 1, 3'd5, 16'h0,    16'h8006, 10'h00C, 0, 0};
    tbl[19] = '{0, mk(16'h0000, 5, 5, 0),  1, 0, 0, 1, 0, 0, 1, 3'd3, 16'h0,    16'hFFFB, 10'h00D, 1, 0};

    idle();
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; instr = tbl[i].ins; s_inc = tbl[i].inc;
      s_call = tbl[i].call; s_ret = tbl[i].ret; s_inm = tbl[i].inm;
      s_datos = tbl[i].sdat; we3 = tbl[i].we; wez = tbl[i].wz;
      op_alu = tbl[i].op; datos = tbl[i].dat;
      #1;
      if (!tbl[i].rst) chk($sformatf("tbl%0d_dir", i), direcciones, tbl[i].e_dir);
      step();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].e_z);
      chk($sformatf("tbl%0d_cnt", i), stk_cnt, tbl[i].e_cnt);
    end

    // Nine calls into an 8-deep stack, then eight LIFO returns.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      idle(); s_call = 1; instr = 32'h100 + 32'h10 * (k - 1);
      step();
      if (k <= 8) begin
        chk($sformatf("call%0d_pc", k), pc, 32'h100 + 32'h10 * (k - 1));
        chk($sformatf("call%0d_cnt", k), stk_cnt, k);
      end else begin
        chk("call9_pc", pc, 32'h171);
        chk("call9_cnt", stk_cnt, 8);
        chk("call9_ovf", stk_ovf, 1);
      end
    end
    for (int k = 8; k >= 1; k--) begin
      idle(); s_ret = 1;
      step();
      chk($sformatf("ret%0d_pc", k), pc, before_call(k) + 1);
    end
    chk("unwound_cnt", stk_cnt, 0);
    idle(); step();
    chk("ovf_sticky", stk_ovf, 1);

    // Underflow at the top of the PC range wraps to 0; then illegal call+ret.
    do_reset();
    idle(); s_inc = 0; instr = 32'h3FF; step();
    chk("jmp_3ff", pc, 10'h3FF);
    idle(); s_ret = 1; step();
    chk("unf_pc_wrap", pc, 0);
    chk("unf_set", stk_unf, 1);
    for (int i = 0; i < 3; i++) begin
      idle(); step();
      chk("unf_sticky", stk_unf, 1);
    end
    idle(); s_call = 1; s_ret = 1; instr = 32'h055; step();
    chk("illegal_pc", pc, 4);
    chk("illegal_flags", {stk_ovf, stk_unf}, 2'b11);
    chk("illegal_cnt", stk_cnt, 0);

    // Stall holds everything; reset overrides a stall.
    do_reset();
    idle(); instr = mk(16'h1234, 0, 0, 1); we3 = 1; step();
    idle(); s_inm = 1; wez = 1; step();
    idle(); s_call = 1; instr = 32'h0AB; step();
    chk("pre_stall_pc", pc, 10'h0AB);
    for (int i = 0; i < 3; i++) begin
      idle(); en = 0; s_call = 1; we3 = 1; wez = 1; instr = mk(16'h0001, 1, 0, 1);
      step();
      chk("stall_pc", pc, 10'h0AB);
      chk("stall_cnt", stk_cnt, 1);
      chk("stall_z", z, 1);
      chk("stall_r1", direcciones, 16'h1234);
    end
    reset = 1; step(); reset = 0;
    chk("midrst_pc", pc, 0);
    chk("midrst_cnt", stk_cnt, 0);
    chk("midrst_z", z, 0);
    chk("midrst_flags", {stk_ovf, stk_unf}, 0);
    idle(); instr = mk(16'h0000, 1, 0, 0); #1;
    chk("midrst_r1", direcciones, 0);
    step();

    // Random stimulus, alternating call-heavy and return-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      bit call_heavy;
      call_heavy = ((i / 200) % 2) == 0;
      reset   = ($urandom_range(0, 299) == 0);
      en      = ($urandom_range(0, 7) != 0);
      instr   = $urandom;
      s_inc   = $urandom_range(0, 3) != 0;
      s_call  = call_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      s_ret   = call_heavy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
      s_inm   = 1'($urandom);
      s_datos = 1'($urandom);
      we3     = 1'($urandom);
      wez     = 1'($urandom);
      op_alu  = 3'($urandom);
      datos   = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
